// File: rtl/id_pipe_ctrl_pkg.sv
// Shared types and constants for the decode-stage sequencer.
// Holds the state encoding, the NOP encoding and the default PC width.
package id_pipe_ctrl_pkg;

    localparam int unsigned PC_WIDTH_DEF = 10;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StFreeze = 2'd1,
        StFlush  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/id_pipe_ctrl_hazard_unit.sv
// Combinational load-use compare between the instruction in ID and a load in EX.
// Kept separate so forwarding detection can reuse the same address match.
module hazard_unit (
    input  logic       id_valid,
    input  logic       ex_valid,
    input  logic       id_rs1_re,
    input  logic [4:0] id_rs1_addr,
    input  logic       id_rs2_re,
    input  logic [4:0] id_rs2_addr,
    input  logic       ex_is_load,
    input  logic       ex_rd_we,
    input  logic [4:0] ex_rd_addr,
    output logic       lu
);

    logic rs1_hit;
    logic rs2_hit;
    logic ex_writes;

    assign ex_writes = ex_valid & ex_is_load & ex_rd_we & (ex_rd_addr != 5'd0);
    assign rs1_hit   = id_rs1_re & (id_rs1_addr == ex_rd_addr);
    assign rs2_hit   = id_rs2_re & (id_rs2_addr == ex_rd_addr);
    assign lu        = id_valid & ex_writes & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_pipe_ctrl.sv
// Decode-stage sequencer: owns IF/ID and the ID/EX valid bit, and arbitrates
// memory freezes, EX redirects and load-use stalls; counts stall cycles.
module id_pipe_ctrl
    import id_pipe_ctrl_pkg::*;
#(
    parameter int unsigned PC_WIDTH  = PC_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_valid,
    input  logic [PC_WIDTH-1:0]  if_pc,
    input  logic [31:0]          if_inst,
    output logic                 if_ready,
    output logic                 id_valid,
    output logic [PC_WIDTH-1:0]  id_pc,
    output logic [31:0]          id_inst,
    input  logic                 id_rs1_re,
    input  logic                 id_rs2_re,
    input  logic [4:0]           id_rs1_addr,
    input  logic [4:0]           id_rs2_addr,
    input  logic                 ex_is_load,
    input  logic                 ex_rd_we,
    input  logic [4:0]           ex_rd_addr,
    input  logic                 ex_redirect,
    input  logic                 mem_busy,
    output logic                 id_ex_en,
    output logic                 id_ex_bubble,
    output logic                 ex_valid,
    input  logic                 perf_clr,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    pipe_state_e          state_q, state_d;
    pipe_state_e          saved_q, saved_d;
    pipe_state_e          eff_state;
    logic                 redirect_pend_q, redirect_pend_d;
    logic                 id_valid_q, id_valid_d;
    logic [PC_WIDTH-1:0]  id_pc_q, id_pc_d;
    logic [31:0]          id_inst_q, id_inst_d;
    logic                 ex_valid_q, ex_valid_d;
    logic [CNT_WIDTH-1:0] stall_q;
    logic                 lu;

    hazard_unit u_hazard (
        .id_valid    (id_valid_q),
        .ex_valid    (ex_valid_q),
        .id_rs1_re   (id_rs1_re),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_re   (id_rs2_re),
        .id_rs2_addr (id_rs2_addr),
        .ex_is_load  (ex_is_load),
        .ex_rd_we    (ex_rd_we),
        .ex_rd_addr  (ex_rd_addr),
        .lu          (lu)
    );

    // Leaving FREEZE acts immediately as the state that was interrupted.
    assign eff_state = (state_q == StFreeze) ? saved_q : state_q;

    always_comb begin
        state_d         = state_q;
        saved_d         = saved_q;
        redirect_pend_d = redirect_pend_q;
        id_valid_d      = id_valid_q;
        id_pc_d         = id_pc_q;
        id_inst_d       = id_inst_q;
        ex_valid_d      = ex_valid_q;
        if_ready        = 1'b0;
        id_ex_en        = 1'b0;
        id_ex_bubble    = 1'b0;

        if (!rst) begin
            id_ex_bubble = 1'b1;
        end else if (mem_busy) begin
            state_d         = StFreeze;
            redirect_pend_d = redirect_pend_q | ex_redirect;
            if (state_q != StFreeze) begin
                saved_d = state_q;
            end
        end else if (redirect_pend_q || (eff_state == StRun && ex_redirect)) begin
            if_ready        = 1'b1;
            id_ex_en        = 1'b1;
            id_ex_bubble    = 1'b1;
            id_valid_d      = 1'b0;
            id_inst_d       = INST_NOP;
            ex_valid_d      = 1'b0;
            redirect_pend_d = 1'b0;
            state_d         = StFlush;
        end else if (eff_state == StFlush) begin
            // Drop the wrong-path fetch that was already in flight.
            if_ready     = 1'b1;
            id_ex_en     = 1'b1;
            id_ex_bubble = 1'b1;
            id_valid_d   = 1'b0;
            id_inst_d    = INST_NOP;
            ex_valid_d   = 1'b0;
            state_d      = StRun;
        end else if (lu) begin
            id_ex_en     = 1'b1;
            id_ex_bubble = 1'b1;
            ex_valid_d   = 1'b0;
            state_d      = StRun;
        end else begin
            if_ready   = 1'b1;
            id_ex_en   = 1'b1;
            id_valid_d = if_valid;
            id_pc_d    = if_pc;
            id_inst_d  = if_inst;
            ex_valid_d = id_valid_q;
            state_d    = StRun;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= StRun;
            saved_q         <= StRun;
            redirect_pend_q <= 1'b0;
            id_valid_q      <= 1'b0;
            id_pc_q         <= '0;
            id_inst_q       <= INST_NOP;
            ex_valid_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            saved_q         <= saved_d;
            redirect_pend_q <= redirect_pend_d;
            id_valid_q      <= id_valid_d;
            id_pc_q         <= id_pc_d;
            id_inst_q       <= id_inst_d;
            ex_valid_q      <= ex_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (perf_clr) begin
            stall_q <= '0;
        end else if ((!if_ready || id_ex_bubble) && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_WIDTH'(1);
        end
    end

    assign id_valid     = id_valid_q;
    assign id_pc        = id_pc_q;
    assign id_inst      = id_inst_q;
    assign ex_valid     = ex_valid_q;
    assign stall_cycles = stall_q;

endmodule

// File: doc/id_pipe_ctrl.md
# id_pipe_ctrl

Sequencer for the decode stage of the RV32I core. Owns the IF/ID pipeline register and the ID/EX valid bit, and decides each cycle whether fetch advances, whether decode is held, and whether a bubble is injected into EX. It sits between fetch, the ID decoder (consuming its register-read enables and addresses) and EX (consuming load/redirect status). It resolves load-use hazards, branch/jump redirects and data-memory busy stalls, and keeps a saturating stall-cycle counter.

## Interface
- PC_WIDTH, 10 (from `defines_bitwidth.vh`), program-counter width
- CNT_WIDTH, 16, stall-counter width
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_valid  in  1  fetch presents an instruction this cycle
- if_pc  in  PC_WIDTH  fetched PC
- if_inst  in  32  fetched instruction
- if_ready  out  1  fetch may advance its PC this cycle
- id_valid  out  1  IF/ID register holds a live instruction
- id_pc  out  PC_WIDTH  IF/ID PC, drives ID `pc_i`
- id_inst  out  32  IF/ID instruction, drives ID `id_inst`
- id_rs1_re, id_rs2_re  in  1 each  read enables from ID
- id_rs1_addr, id_rs2_addr  in  5 each  source register addresses from ID
- ex_is_load  in  1  instruction in EX is a load
- ex_rd_we  in  1  instruction in EX writes rd
- ex_rd_addr  in  5  rd of the instruction in EX
- ex_redirect  in  1  EX resolved a taken branch, JAL or JALR this cycle
- mem_busy  in  1  data memory not ready; the whole pipe freezes
- id_ex_en  out  1  ID/EX register load enable
- id_ex_bubble  out  1  load a NOP into ID/EX instead of the ID output
- ex_valid  out  1  ID/EX holds a live instruction
- perf_clr  in  1  synchronous clear of stall_cycles
- stall_cycles  out  CNT_WIDTH  saturating count of stall/bubble cycles

## Operation
- States: RUN, FREEZE, FLUSH.
- Load-use hazard (lu): id_valid & ex_valid & ex_is_load & ex_rd_we & ex_rd_addr≠0, and either (id_rs1_re & id_rs1_addr==ex_rd_addr) or (id_rs2_re & id_rs2_addr==ex_rd_addr).
- Priority in RUN: mem_busy > ex_redirect > lu > normal.
- RUN, normal: if_ready=1, id_ex_en=1, id_ex_bubble=0. IF/ID loads if_valid/if_pc/if_inst. ex_valid takes id_valid.
- RUN, lu: if_ready=0. IF/ID holds. id_ex_en=1, id_ex_bubble=1, ex_valid takes 0. The next cycle re-evaluates; the hazard has cleared.
- RUN, ex_redirect: if_ready=1. IF/ID is cleared: id_valid=0, id_inst=NOP (32'h0000_0013). The ID/EX bubble is applied, ex_valid takes 0, and the state goes to FLUSH.
- FLUSH (one cycle): discards the wrong-path if_valid that was already in flight. IF/ID stays invalid/NOP, the ID/EX bubble is applied, and the state returns to RUN. A new ex_redirect cannot occur because EX holds a bubble.
- mem_busy in any state: the state goes to FREEZE with if_ready=0 and id_ex_en=0. IF/ID, ex_valid and state are held. An ex_redirect seen while frozen is latched in redirect_pend.
- FREEZE: exit when mem_busy=0. If redirect_pend is set, take the RUN/ex_redirect action and clear it. Otherwise return to the state saved on entry (RUN or FLUSH).
- stall_cycles: increments by 1 in every cycle with if_ready=0 or id_ex_bubble=1. It saturates at all-ones. perf_clr has priority over increment.

## Timing
- Reset values (async, active-low): state=RUN, id_valid=0, id_pc=0, id_inst=NOP, ex_valid=0, redirect_pend=0, stall_cycles=0.
- Combinational outputs during reset: if_ready=0, id_ex_en=0, id_ex_bubble=1.
- Release of rst is synchronised externally; the first edge after release operates normally.
- if_ready, id_ex_en and id_ex_bubble are combinational from the state and the current-cycle inputs. There is no register between hazard detection and control.
- All other state updates happen at the rising edge.
- Latency: IF→ID is 1 cycle. The load-use penalty is 1 bubble. The redirect penalty is 2 bubbles (the redirect edge plus FLUSH).
- Simultaneous lu and ex_redirect: the redirect wins and no stall occurs.
- Simultaneous mem_busy and ex_redirect: freeze, with the redirect pending.
- rst asserted mid-stall or mid-flush: immediately returns to the reset values; the pending redirect is lost.

## Structure
- Shared header `defines_pipe.vh`: state encodings (RUN=2'd0, FREEZE=2'd1, FLUSH=2'd2) and INST_NOP=32'h0000_0013. PC_WIDTH stays in `defines_bitwidth.vh`.
- One sub-module, `hazard_unit`: purely combinational lu compare, reused later for forwarding detection.

## Test plan
- Reset, then release with if_valid=1 and if_inst=0x00500093 at pc 4 → the next edge gives id_valid=1, id_pc=4, id_inst=0x00500093, and stall_cycles=0.
- Load x5 in EX (ex_is_load=1, ex_rd_addr=5); ID uses rs2=x5 with re=1 → if_ready=0 and id_ex_bubble=1 for exactly 1 cycle, IF/ID unchanged, stall_cycles=1. Repeat with ex_rd_addr=0 → no stall.
- ex_redirect pulse → id_inst=NOP, id_valid=0, and 2 consecutive bubbles. The wrong-path if_inst in the FLUSH cycle never reaches id_valid=1.
- mem_busy high for 3 cycles with ex_redirect in the 2nd → all registers frozen for 3 cycles; the redirect action happens on the first cycle after mem_busy falls, then FLUSH.
- lu and ex_redirect in the same cycle → redirect action only, no lu stall.
- Force 65 540 stall cycles → stall_cycles holds at 0xFFFF. perf_clr concurrent with a stall → 0.
